// File: rtl/sd_pattern_player.sv
// sd_pattern_player
//   Self-test stimulus/response player for the MIMO sphere-decoder path.
//   A pattern RAM holds {flag, word} entries that are streamed into the
//   detector; a golden RAM holds the expected detector outputs. Each output
//   word returned by the detector is compared against the golden RAM and
//   the run reports cycle, output and error counts.
//
// Handshake (o_in_valid / i_in_ready): an entry transfers on a rising edge
//   where both are high. While o_in_valid is high and i_in_ready is low,
//   o_flag/o_data hold their value. o_in_valid never drops without a
//   transfer, except on timeout or Reset.
//
// Ports
//   Clk, Reset             clock; synchronous active-high reset
//   start                  begin a run (accepted in IDLE/DONE/TIMEOUT only)
//   pat_len, exp_len       entries to send / outputs to check, sampled on start
//   wr_en/wr_sel/wr_addr/wr_data  RAM load port (sel 0 = pattern, 1 = golden)
//   o_in_valid/o_flag/o_data/i_in_ready  stream into the detector
//   i_out_valid/i_out_data detector outputs
//   busy, done, timeout    run status
//   cycle_cnt/out_cnt/err_cnt  run statistics
//   dbg_state              current FSM state
module sd_pattern_player #(
  parameter int I_WIDTH   = 16,
  parameter int N_ANT     = 4,
  parameter int O_WIDTH   = 12,
  parameter int PAT_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int MAX_CYCLE = 100000,
  parameter int CNT_W     = 32
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           start,
  input  logic [ADDR_W:0]                pat_len,
  input  logic [ADDR_W:0]                exp_len,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [I_WIDTH*N_ANT*2:0]       wr_data,
  output logic                           o_in_valid,
  output logic                           o_flag,
  output logic [I_WIDTH*N_ANT*2-1:0]     o_data,
  input  logic                           i_in_ready,
  input  logic                           i_out_valid,
  input  logic [O_WIDTH-1:0]             i_out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [CNT_W-1:0]               cycle_cnt,
  output logic [ADDR_W:0]                out_cnt,
  output logic [ADDR_W:0]                err_cnt,
  output logic [2:0]                     dbg_state
);

  localparam int DW = I_WIDTH * N_ANT * 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DW:0]        pat_ram  [PAT_DEPTH];
  logic [O_WIDTH-1:0] gold_ram [PAT_DEPTH];

  logic [ADDR_W:0] pat_len_q, exp_len_q;
  logic [ADDR_W:0] rd_ptr;       // index of the entry currently presented
  logic [ADDR_W:0] nxt_ptr;
  logic            accept, xfer, last_xfer, chk, mismatch, hit_max, wr_ok;
  logic [ADDR_W:0] out_cnt_nx;
  logic [CNT_W-1:0] cyc_nx;

  assign busy      = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign timeout   = (state_q == S_TIMEOUT);
  assign dbg_state = state_q;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_TIMEOUT));
  assign xfer      = (state_q == S_FEED) && o_in_valid && i_in_ready;
  assign last_xfer = xfer && (rd_ptr == pat_len_q - {{ADDR_W{1'b0}}, 1'b1});
  assign nxt_ptr   = rd_ptr + {{ADDR_W{1'b0}}, 1'b1};

  // Outputs past exp_len are ignored; out_cnt < exp_len <= PAT_DEPTH keeps
  // the golden index in range whenever chk is set.
  assign chk        = busy && i_out_valid && (out_cnt < exp_len_q);
  assign mismatch   = chk && (i_out_data != gold_ram[out_cnt[ADDR_W-1:0]]);
  assign out_cnt_nx = out_cnt + {{ADDR_W{1'b0}}, chk};

  assign cyc_nx  = cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign hit_max = busy && (cyc_nx == CNT_W'(MAX_CYCLE - 1));

  // Loads are locked out during a run and on the cycle a start is taken,
  // so a run always sees the RAM image that existed when it began.
  assign wr_ok = wr_en && !busy && !accept;

  always_ff @(posedge Clk) begin
    if (wr_ok) begin
      if (wr_sel) gold_ram[wr_addr] <= wr_data[O_WIDTH-1:0];
      else        pat_ram[wr_addr]  <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (accept) state_d = (pat_len == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (last_xfer) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // includes an output checked on this very cycle
        if (out_cnt_nx == exp_len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    // timeout takes priority over a same-cycle completion
    if (hit_max) state_d = S_TIMEOUT;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pat_len_q  <= '0;
      exp_len_q  <= '0;
      rd_ptr     <= '0;
      o_in_valid <= 1'b0;
      o_flag     <= 1'b0;
      o_data     <= '0;
      cycle_cnt  <= '0;
      out_cnt    <= '0;
      err_cnt    <= '0;
    end else if (accept) begin
      pat_len_q  <= pat_len;
      exp_len_q  <= exp_len;
      rd_ptr     <= '0;
      cycle_cnt  <= '0;
      out_cnt    <= '0;
      err_cnt    <= '0;
      o_in_valid <= (pat_len != '0);
      {o_flag, o_data} <= pat_ram[0];
    end else begin
      if (busy) cycle_cnt <= cyc_nx;
      if (chk)  out_cnt   <= out_cnt_nx;
      if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      // Output register doubles as the synchronous RAM read: the next entry
      // is fetched on the transfer edge, giving one transfer per cycle.
      if (xfer) begin
        if (last_xfer) begin
          o_in_valid <= 1'b0;
        end else begin
          rd_ptr <= nxt_ptr;
          {o_flag, o_data} <= pat_ram[nxt_ptr[ADDR_W-1:0]];
        end
      end
      if (hit_max) o_in_valid <= 1'b0;
    end
  end

endmodule
